// File: rtl/mux_scan_n_if.sv
// rtl/mux_scan_n_if.sv - channel inputs and registered mux outputs for mux_scan_n
interface mux_scan_n_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*WIDTH-1:0] din;
  logic [SEL_W-1:0]     sel;
  logic                 mode;
  logic                 hold;
  logic [WIDTH-1:0]     y;
  logic                 y_valid;
  logic [SEL_W-1:0]     cur_ch;
  logic                 wrap;

  modport master (output din, sel, mode, hold, input y, y_valid, cur_ch, wrap);
  modport slave  (input din, sel, mode, hold, output y, y_valid, cur_ch, wrap);
endinterface

// File: rtl/mux_scan_n.sv
// rtl/mux_scan_n.sv - registered N-channel mux with manual select and auto-scan modes
module mux_scan_n #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_scan_n_if.slave bus
);
  localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W = $clog2(DWELL) + 1;

  typedef enum logic {MANUAL, SCAN} state_t;

  state_t           state;
  logic [CNT_W-1:0] dwell_cnt;
  logic [SEL_W-1:0] cur_ch_r;
  logic [WIDTH-1:0] y_r;
  logic             y_valid_r;
  logic             wrap_r;

  logic [CNT_W-1:0] cnt_eff;
  logic [CNT_W-1:0] next_cnt;
  logic [SEL_W-1:0] next_ch;
  logic [WIDTH-1:0] next_data;
  logic             next_valid;
  logic             next_wrap;
  logic             sel_ok;
  logic             at_last_ch;
  logic             at_term;

  always_comb begin
    // The first SCAN edge after MANUAL always starts a fresh dwell.
    cnt_eff    = (state == SCAN) ? dwell_cnt : '0;
    sel_ok     = (32'(bus.sel) < NCH);
    at_last_ch = (32'(cur_ch_r) == NCH - 1);
    at_term    = (32'(cnt_eff) == DWELL - 1);
    next_ch    = cur_ch_r;
    next_cnt   = '0;
    next_valid = 1'b1;
    next_wrap  = 1'b0;
    if (!bus.mode) begin
      if (sel_ok) next_ch = bus.sel;
      else        next_valid = 1'b0;
    end else if (bus.hold) begin
      next_cnt = cnt_eff;
    end else if (!at_term) begin
      next_cnt = cnt_eff + CNT_W'(1);
    end else begin
      next_ch   = at_last_ch ? '0 : cur_ch_r + SEL_W'(1);
      next_wrap = at_last_ch;
    end
  end

  always_comb begin
    next_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (32'(next_ch) == k) next_data = bus.din[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MANUAL;
      dwell_cnt <= '0;
      cur_ch_r  <= '0;
      y_r       <= '0;
      y_valid_r <= 1'b0;
      wrap_r    <= 1'b0;
    end else begin
      state     <= bus.mode ? SCAN : MANUAL;
      dwell_cnt <= next_cnt;
      cur_ch_r  <= next_ch;
      y_r       <= next_valid ? next_data : '0;
      y_valid_r <= next_valid;
      wrap_r    <= next_wrap;
    end
  end

  assign bus.y       = y_r;
  assign bus.y_valid = y_valid_r;
  assign bus.cur_ch  = cur_ch_r;
  assign bus.wrap    = wrap_r;
endmodule

// File: tb/tb_mux_scan_n.sv
// tb/tb_mux_scan_n.sv - directed and random checks of mux_scan_n against a scan-position model
module tb_mux_scan_n;
  typedef struct {
    int pos;
    int valid;
    int y;
    int wrap;
  } ms_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din4 = 32'hDDCCBBAA;
  logic [1:0]  sel = '0;
  logic        mode = 1'b0;
  logic        hold = 1'b0;

  int errors = 0;
  int checks = 0;
  ms_t m4, m3;
  ms_t m_rst = '{pos: 0, valid: 0, y: 0, wrap: 0};

  mux_scan_n_if #(.WIDTH(8), .NCH(4)) b4 ();
  mux_scan_n_if #(.WIDTH(8), .NCH(3)) b3 ();

  assign b4.din  = din4;
  assign b4.sel  = sel;
  assign b4.mode = mode;
  assign b4.hold = hold;
  assign b3.din  = din4[23:0];
  assign b3.sel  = sel;
  assign b3.mode = mode;
  assign b3.hold = hold;

  mux_scan_n #(.WIDTH(8), .NCH(4), .DWELL(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  mux_scan_n #(.WIDTH(8), .NCH(3), .DWELL(1)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  always #5 clk = ~clk;

  // Scan position = channel*dwell + elapsed dwell; one linear counter modulo nch*dwell.
  function automatic ms_t mstep(ms_t s, logic [31:0] din, int sl, bit md, bit hd, int nch, int dwell);
    ms_t n = s;
    n.wrap = 0;
    if (!md) begin
      if (sl < nch) begin
        n.pos   = sl * dwell;
        n.valid = 1;
        n.y     = int'((din >> (8 * sl)) & 32'hFF);
      end else begin
        n.pos   = (s.pos / dwell) * dwell;
        n.valid = 0;
        n.y     = 0;
      end
    end else begin
      if (!hd) begin
        n.pos  = (s.pos + 1) % (nch * dwell);
        n.wrap = (n.pos == 0) ? 1 : 0;
      end
      n.valid = 1;
      n.y     = int'((din >> (8 * (n.pos / dwell))) & 32'hFF);
    end
    return n;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("u4_y",     32'(b4.y),       m4.y);
    chk("u4_valid", 32'(b4.y_valid), m4.valid);
    chk("u4_ch",    32'(b4.cur_ch),  m4.pos / 4);
    chk("u4_wrap",  32'(b4.wrap),    m4.wrap);
    chk("u3_y",     32'(b3.y),       m3.y);
    chk("u3_valid", 32'(b3.y_valid), m3.valid);
    chk("u3_ch",    32'(b3.cur_ch),  m3.pos);
    chk("u3_wrap",  32'(b3.wrap),    m3.wrap);
  endtask

  task automatic step();
    @(posedge clk);
    m4 = mstep(m4, din4, int'(sel), mode, hold, 4, 4);
    m3 = mstep(m3, {8'h00, din4[23:0]}, int'(sel), mode, hold, 3, 1);
    #1;
    check_all();
  endtask

  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    m4 = m_rst;
    m3 = m_rst;
    check_all();
    rst_n = 1'b1;
  endtask

  int w4, w3, wrap_at;

  initial begin
    m4 = m_rst;
    m3 = m_rst;
    #12;
    check_all();
    rst_n = 1'b1;

    // Manual select, including an out-of-range select on the 3-channel unit
    sel = 2'd2;
    step();
    chk("t2_y_cc", 32'(b4.y), 32'hCC);
    chk("t2_ch2", 32'(b4.cur_ch), 32'd2);
    sel = 2'd3;
    step();
    chk("t2_y_dd", 32'(b4.y), 32'hDD);
    chk("t5_u3_y0", 32'(b3.y), 32'h00);
    chk("t5_u3_invalid", 32'(b3.y_valid), 32'd0);

    // Asynchronous reset with no clock edge
    mode = 1'b1;
    step();
    step();
    mid_reset();
    chk("t1_y0", 32'(b4.y), 32'h00);

    // 20-clock scan from channel 0
    mode = 1'b0;
    sel  = 2'd0;
    step();
    mode = 1'b1;
    w4 = 0; w3 = 0; wrap_at = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (b4.wrap === 1'b1) begin w4++; wrap_at = i; end
      if (b3.wrap === 1'b1) w3++;
    end
    chk("t3_wrap_cnt", w4, 1);
    chk("t3_wrap_at", wrap_at, 16);
    chk("t5_u3_wraps", w3, 6);

    // Hold at channel 1, dwell 2
    mode = 1'b0;
    sel  = 2'd1;
    step();
    mode = 1'b1;
    step();
    step();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_y", 32'(b4.y), 32'hBB);
      chk("t4_hold_ch", 32'(b4.cur_ch), 32'd1);
    end
    hold = 1'b0;
    step();
    chk("t4_rel_bb", 32'(b4.y), 32'hBB);
    step();
    chk("t4_rel_cc", 32'(b4.y), 32'hCC);

    // Reset mid-scan at channel 2, then manual and a fresh scan
    mode = 1'b0;
    sel  = 2'd2;
    step();
    mode = 1'b1;
    step();
    step();
    mid_reset();
    mode = 1'b0;
    sel  = 2'd0;
    step();
    chk("t6_y_aa", 32'(b4.y), 32'hAA);
    mode = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("t6_still_aa", 32'(b4.y), 32'hAA);
    step();
    chk("t6_then_bb", 32'(b4.y), 32'hBB);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      din4 = $urandom;
      sel  = 2'($urandom_range(0, 3));
      mode = ($urandom_range(0, 9) < 8);
      hold = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) mid_reset();
      else step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
